// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 controller constants, FSM state encoding and IV values.
// The SHA-224 IV is consumed by the datapath when SHA256_CTRL_SHA224_EN is defined.
package sha256_pkg;

    localparam int DEF_NUM_ROUNDS = 64;
    localparam int DEF_ROUND_W    = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUNDS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // H0..H7 packed with H0 in the most significant word
    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] SHA224_IV = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] iv_word(input logic sel_224, input logic [2:0] idx);
        logic [255:0] iv;
        iv = sel_224 ? SHA224_IV : SHA256_IV;
        return iv[255 - 32*idx -: 32];
    endfunction

endpackage

// File: rtl/sha256_round_ctr.sv
// sha256_round_ctr: round index counter with terminal count; wraps to 0 after the last round
// so the index already reads 0 when the controller returns to idle.
module sha256_round_ctr
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int ROUND_W    = DEF_ROUND_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               enable,
    output logic [ROUND_W-1:0] round_idx,
    output logic               last_round
);

    assign last_round = round_idx == ROUND_W'(NUM_ROUNDS - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            round_idx <= '0;
        else if (clear)
            round_idx <= '0;
        else if (enable)
            round_idx <= last_round ? '0 : round_idx + ROUND_W'(1);
    end

endmodule

// File: rtl/sha256_ctrl.sv
// sha256_ctrl: SHA-256 compression control FSM (IDLE -> ROUNDS -> DONE) driving datapath strobes.
// Optional SHA-224 mode tracking is enabled by defining SHA256_CTRL_SHA224_EN.
module sha256_ctrl
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int ROUND_W    = DEF_ROUND_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               init,
    input  logic               next,
`ifdef SHA256_CTRL_SHA224_EN
    input  logic               mode,
    output logic               mode_224,
`endif
    output logic               ready,
    output logic               digest_valid,
    output logic               digest_init,
    output logic               state_init,
    output logic               w_init,
    output logic               w_next,
    output logic               state_update,
    output logic               digest_update,
    output logic [ROUND_W-1:0] round_idx
);

    state_t state, state_nxt;
    logic   accept;
    logic   count_en;
    logic   last_round;

    sha256_round_ctr #(
        .NUM_ROUNDS(NUM_ROUNDS),
        .ROUND_W   (ROUND_W)
    ) u_round_ctr (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (accept),
        .enable    (count_en),
        .round_idx (round_idx),
        .last_round(last_round)
    );

    assign ready = state == IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // init takes priority over next; commands outside IDLE are dropped
    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        count_en      = 1'b0;
        digest_init   = 1'b0;
        state_init    = 1'b0;
        w_init        = 1'b0;
        w_next        = 1'b0;
        state_update  = 1'b0;
        digest_update = 1'b0;
        case (state)
            IDLE: begin
                if (init || next) begin
                    accept      = 1'b1;
                    digest_init = init;
                    state_init  = 1'b1;
                    w_init      = 1'b1;
                    state_nxt   = ROUNDS;
                end
            end
            ROUNDS: begin
                count_en     = 1'b1;
                w_next       = 1'b1;
                state_update = 1'b1;
                state_nxt    = last_round ? DONE : ROUNDS;
            end
            DONE: begin
                digest_update = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            digest_valid <= 1'b0;
        else if (accept)
            digest_valid <= 1'b0;
        else if (state == DONE)
            digest_valid <= 1'b1;
    end

`ifdef SHA256_CTRL_SHA224_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mode_224 <= 1'b0;
        else if (accept && init)
            mode_224 <= mode;
    end
`endif

endmodule
